// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state encoding
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_STATE_W    = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - FIFO-side handshake, baud tick and serial line bundle for uart_tx
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic                 baud_tick;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_pop;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        input  baud_tick, fifo_empty, fifo_rdata,
        output fifo_pop, tx, tx_busy, tx_done
    );

    modport slave (
        output baud_tick, fifo_empty, fifo_rdata,
        input  fifo_pop, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts baud ticks and flags the tick that ends each bit period
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_tick,
    input  logic clear,
    output logic bit_end
);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] r_tick_cnt;

    // clear wins over baud_tick so a tick on the frame-start edge is not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (clear) begin
            r_tick_cnt <= '0;
        end else if (baud_tick) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
        end
    end

    assign bit_end = baud_tick && !clear && (r_tick_cnt == TICK_LAST);
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-draining UART transmitter, 8N1 or 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.master   bus
);
    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_e          r_state, w_next_state;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_pop, w_pop_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_bit_end;
    logic                 w_clear;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_nxt;
`endif

    assign w_clear = (r_state == ST_IDLE);

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (bus.baud_tick),
        .clear     (w_clear),
        .bit_end   (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_pop     <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_pop     <= w_pop_nxt;
            r_done    <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // Next values of the registered outputs are decided here so tx only moves on bit boundaries
    always_comb begin
        w_next_state  = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_pop_nxt     = 1'b0;
        w_done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (!bus.fifo_empty) begin
                    w_next_state  = ST_START;
                    w_shift_nxt   = bus.fifo_rdata;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_pop_nxt     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt  = ^bus.fifo_rdata;
`endif
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_next_state = ST_DATA;
                    w_tx_nxt     = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_next_state  = ST_PARITY;
                        w_tx_nxt      = r_parity;
`else
                        w_next_state  = ST_STOP;
                        w_tx_nxt      = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = ST_STOP;
                    w_tx_nxt     = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_next_state = ST_IDLE;
                    w_tx_nxt     = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_tx_nxt     = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.tx       = r_tx;
    assign bus.tx_busy  = r_busy;
    assign bus.fifo_pop = r_pop;
    assign bus.tx_done  = r_done;
endmodule
